// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: pulses fetch/decode/exec/mem/write in turn, owns PC and retired count.
// Latency: 2 cycles per stage minimum (issue + wait); 8 cycles/instr without mem, 10 with mem.
// Backpressure: each stage holds the FSM in its wait state until completed; a watchdog traps hung stages.
module core_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 1024,
    parameter int          WD_W     = 11
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        run,
    input  logic        step_req,
    output logic        f_enabled,
    output logic        d_enabled,
    output logic        e_enabled,
    output logic        m_enabled,
    output logic        w_enabled,
    input  logic        f_completed,
    input  logic        d_completed,
    input  logic        e_completed,
    input  logic        m_completed,
    input  logic        w_completed,
    input  logic [31:0] e_pc_n,
    input  logic        e_mem_access,
    output logic [31:0] pc,
    output logic        busy,
    output logic        halted,
    output logic        err,
    output logic [2:0]  err_stage,
    output logic [31:0] instret
);

    typedef enum logic [3:0] {
        IDLE, F_ISS, F_WAIT, D_ISS, D_WAIT, E_ISS, E_WAIT,
        M_ISS, M_WAIT, W_ISS, W_WAIT, ERROR
    } state_e;

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     npc_q, npc_d;
    logic            mem_q, mem_d;
    logic [31:0]     instret_q, instret_d;
    logic            err_q, err_d;
    logic [2:0]      err_stage_q, err_stage_d;
    logic            retire;
    logic            f_en_q, d_en_q, e_en_q, m_en_q, w_en_q;
    logic            busy_q, halted_q;
    logic            wd_last;

    assign wd_last   = (wd_q == WD_LAST);
    // Retire count wraps naturally at 32 bits.
    assign instret_d = retire ? instret_q + 32'd1 : instret_q;

    // Next-state logic: stage sequencing, watchdog and retire bookkeeping.
    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        pc_d        = pc_q;
        npc_d       = npc_q;
        mem_d       = mem_q;
        err_d       = err_q;
        err_stage_d = err_stage_q;
        retire      = 1'b0;
        case (state_q)
            IDLE:   if (run || step_req) state_d = F_ISS;
            F_ISS:  begin state_d = F_WAIT; wd_d = '0; end
            F_WAIT: begin
                if (f_completed)  state_d = D_ISS;
                else if (wd_last) begin state_d = ERROR; err_d = 1'b1; err_stage_d = 3'd1; end
                else              wd_d = wd_q + WD_W'(1);
            end
            D_ISS:  begin state_d = D_WAIT; wd_d = '0; end
            D_WAIT: begin
                if (d_completed)  state_d = E_ISS;
                else if (wd_last) begin state_d = ERROR; err_d = 1'b1; err_stage_d = 3'd2; end
                else              wd_d = wd_q + WD_W'(1);
            end
            E_ISS:  begin state_d = E_WAIT; wd_d = '0; end
            E_WAIT: begin
                if (e_completed) begin
                    npc_d   = e_pc_n;
                    mem_d   = e_mem_access;
                    state_d = e_mem_access ? M_ISS : W_ISS;
                end
                else if (wd_last) begin state_d = ERROR; err_d = 1'b1; err_stage_d = 3'd3; end
                else              wd_d = wd_q + WD_W'(1);
            end
            M_ISS:  begin state_d = M_WAIT; wd_d = '0; end
            M_WAIT: begin
                if (m_completed)  state_d = W_ISS;
                else if (wd_last) begin state_d = ERROR; err_d = 1'b1; err_stage_d = 3'd4; end
                else              wd_d = wd_q + WD_W'(1);
            end
            W_ISS:  begin state_d = W_WAIT; wd_d = '0; end
            W_WAIT: begin
                if (w_completed) begin
                    pc_d    = npc_q;
                    retire  = 1'b1;
                    state_d = run ? F_ISS : IDLE;
                end
                else if (wd_last) begin state_d = ERROR; err_d = 1'b1; err_stage_d = 3'd5; end
                else              wd_d = wd_q + WD_W'(1);
            end
            ERROR:  state_d = ERROR;
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and registered output flops; outputs are decoded from the next state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            wd_q        <= '0;
            pc_q        <= RESET_PC;
            npc_q       <= '0;
            mem_q       <= 1'b0;
            instret_q   <= '0;
            err_q       <= 1'b0;
            err_stage_q <= '0;
            f_en_q      <= 1'b0;
            d_en_q      <= 1'b0;
            e_en_q      <= 1'b0;
            m_en_q      <= 1'b0;
            w_en_q      <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            wd_q        <= wd_d;
            pc_q        <= pc_d;
            npc_q       <= npc_d;
            mem_q       <= mem_d;
            instret_q   <= instret_d;
            err_q       <= err_d;
            err_stage_q <= err_stage_d;
            f_en_q      <= (state_d == F_ISS);
            d_en_q      <= (state_d == D_ISS);
            e_en_q      <= (state_d == E_ISS);
            m_en_q      <= (state_d == M_ISS);
            w_en_q      <= (state_d == W_ISS);
            busy_q      <= (state_d != IDLE) && (state_d != ERROR);
            halted_q    <= (state_d == IDLE);
        end
    end

    assign f_enabled = f_en_q;
    assign d_enabled = d_en_q;
    assign e_enabled = e_en_q;
    assign m_enabled = m_en_q;
    assign w_enabled = w_en_q;
    assign pc        = pc_q;
    assign busy      = busy_q;
    assign halted    = halted_q;
    assign err       = err_q;
    assign err_stage = err_stage_q;
    assign instret   = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        run = 1'b0;
    logic        step_req = 1'b0;
    logic        f_enabled, d_enabled, e_enabled, m_enabled, w_enabled;
    logic [4:0]  comp = 5'b0;
    logic [31:0] e_pc_n;
    logic        e_mem_access = 1'b0;
    logic [31:0] pc;
    logic        busy, halted, err;
    logic [2:0]  err_stage;
    logic [31:0] instret;

    // Stage model configuration (driven by the main sequence) and state (owned by the responder).
    int          dly [5] = '{0, 0, 0, 0, 0};
    bit          auto_pc = 1'b0;
    logic [31:0] man_epc = 32'h0;
    logic [31:0] auto_epc = 32'h0;
    logic [31:0] next_epc = 32'h200;
    int          cnt [5] = '{0, 0, 0, 0, 0};
    bit          act [5] = '{0, 0, 0, 0, 0};
    int          ecount [5] = '{0, 0, 0, 0, 0};
    int          etime [5] = '{0, 0, 0, 0, 0};
    int          ftime [64];
    int          cyc = 0;
    logic [4:0]  en;

    int checks = 0;
    int errors = 0;

    assign e_pc_n = auto_pc ? auto_epc : man_epc;
    assign en = {w_enabled, m_enabled, e_enabled, d_enabled, f_enabled};

    core_sequencer #(.RESET_PC(32'h100), .TIMEOUT(8), .WD_W(4)) dut (
        .clk(clk), .rstn(rstn), .run(run), .step_req(step_req),
        .f_enabled(f_enabled), .d_enabled(d_enabled), .e_enabled(e_enabled),
        .m_enabled(m_enabled), .w_enabled(w_enabled),
        .f_completed(comp[0]), .d_completed(comp[1]), .e_completed(comp[2]),
        .m_completed(comp[3]), .w_completed(comp[4]),
        .e_pc_n(e_pc_n), .e_mem_access(e_mem_access),
        .pc(pc), .busy(busy), .halted(halted), .err(err),
        .err_stage(err_stage), .instret(instret)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Stage responders: clear completed when enable is seen, raise it after dly wait cycles.
    always @(negedge clk) begin
        for (int s = 0; s < 5; s++) begin
            if (en[s]) begin
                comp[s] = 1'b0;
                cnt[s] = 0;
                act[s] = 1'b1;
                etime[s] = cyc;
                if (s == 0 && ecount[0] < 64) ftime[ecount[0]] = cyc;
                ecount[s]++;
                if (s == 2) begin
                    auto_epc = next_epc;
                    if (auto_pc) next_epc = next_epc + 32'h10;
                end
            end else if (act[s]) begin
                if (cnt[s] == dly[s]) begin
                    comp[s] = 1'b1;
                    act[s] = 1'b0;
                end else begin
                    cnt[s]++;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_step();
        @(negedge clk);
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
    endtask

    task automatic wait_halted(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (halted) begin ok = 1'b1; break; end
        end
    endtask

    initial begin
        bit ok;
        int b0, b1, b2, b3, b4, t0;

        // Reset with RESET_PC=0x100, run=0.
        #2 rstn = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pc", pc, 32'h100);
        check("rst_halted", {31'b0, halted}, 1);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_en", {27'b0, en}, 0);
        check("rst_instret", instret, 0);
        check("rst_err", {28'b0, err, err_stage}, 0);
        rstn = 1'b1;

        // Single step, no mem access, zero-wait stages.
        man_epc = 32'h104;
        e_mem_access = 1'b0;
        b0 = ecount[0]; b1 = ecount[1]; b2 = ecount[2]; b3 = ecount[3]; b4 = ecount[4];
        pulse_step();
        check("step_busy", {31'b0, busy}, 1);
        wait_halted(40, ok);
        check("step_done", {31'b0, ok}, 1);
        check("step_f", ecount[0] - b0, 1);
        check("step_d", ecount[1] - b1, 1);
        check("step_e", ecount[2] - b2, 1);
        check("step_m", ecount[3] - b3, 0);
        check("step_w", ecount[4] - b4, 1);
        check("step_pc", pc, 32'h104);
        check("step_instret", instret, 1);

        // Free-running with mem access: 10-cycle instruction period.
        auto_pc = 1'b1;
        e_mem_access = 1'b1;
        b0 = ecount[0]; b3 = ecount[3];
        @(negedge clk);
        run = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ecount[0] >= b0 + 3) begin ok = 1'b1; break; end
        end
        check("run_reach3", {31'b0, ok}, 1);
        check("run_period1", ftime[b0 + 1] - ftime[b0], 10);
        check("run_period2", ftime[b0 + 2] - ftime[b0 + 1], 10);
        check("run_pc", pc, 32'h210);
        check("run_instret", instret, 3);
        check("run_m", ecount[3] - b3, 2);

        // Drop run during D_WAIT: instruction finishes, then idle.
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (d_enabled) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("stop_seen_d", {31'b0, ok}, 1);
        @(negedge clk);
        run = 1'b0;
        wait_halted(40, ok);
        check("stop_done", {31'b0, ok}, 1);
        check("stop_instret", instret, 4);
        check("stop_pc", pc, 32'h220);
        b0 = ecount[0];
        repeat (20) @(negedge clk);
        check("stop_no_fetch", ecount[0] - b0, 0);
        check("stop_halted", {31'b0, halted}, 1);

        // Exec completes in its 8th wait cycle: completion wins over watchdog.
        dly[2] = 7;
        b3 = ecount[3];
        pulse_step();
        wait_halted(60, ok);
        check("late_done", {31'b0, ok}, 1);
        check("late_err", {31'b0, err}, 0);
        check("late_e_to_m", etime[3] - etime[2], 9);
        check("late_m", ecount[3] - b3, 1);
        check("late_pc", pc, 32'h230);
        check("late_instret", instret, 5);
        dly[2] = 0;

        // Retire counter wrap.
        @(negedge clk);
        force dut.instret_d = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 release dut.instret_d;
        @(negedge clk);
        check("wrap_pre", instret, 32'hFFFF_FFFF);
        pulse_step();
        wait_halted(40, ok);
        check("wrap_done", {31'b0, ok}, 1);
        check("wrap_instret", instret, 0);
        check("wrap_pc", pc, 32'h240);

        // Asynchronous reset in M_WAIT.
        dly[3] = 100;
        b3 = ecount[3];
        pulse_step();
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ecount[3] > b3) begin ok = 1'b1; break; end
        end
        check("mrst_seen_m", {31'b0, ok}, 1);
        @(negedge clk);
        check("mrst_busy_pre", {31'b0, busy}, 1);
        #2 rstn = 1'b0;
        #1;
        check("mrst_busy", {31'b0, busy}, 0);
        check("mrst_en", {27'b0, en}, 0);
        check("mrst_pc", pc, 32'h100);
        check("mrst_instret", instret, 0);
        check("mrst_halted", {31'b0, halted}, 1);
        @(negedge clk);
        rstn = 1'b1;
        dly[3] = 0;

        // Decode hangs: watchdog trips after 8 wait cycles.
        dly[1] = 100;
        pulse_step();
        ok = 1'b0;
        t0 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (err) begin ok = 1'b1; t0 = cyc; break; end
        end
        check("wd_trip", {31'b0, ok}, 1);
        check("wd_cycles", t0 - etime[1], 9);
        check("wd_stage", {29'b0, err_stage}, 2);
        check("wd_busy", {31'b0, busy}, 0);
        check("wd_halted", {31'b0, halted}, 0);
        b0 = ecount[0]; b1 = ecount[1];
        run = 1'b1;
        pulse_step();
        repeat (20) @(negedge clk);
        check("err_no_fetch", ecount[0] - b0, 0);
        check("err_no_decode", ecount[1] - b1, 0);
        check("err_sticky", {28'b0, err, err_stage}, 32'h0A);
        check("err_pc", pc, 32'h100);
        check("err_instret", instret, 0);
        run = 1'b0;
        dly[1] = 0;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("err_clear", {28'b0, err, err_stage}, 0);
        check("err_clear_halted", {31'b0, halted}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
